// File: rtl/block_unbatcher.sv
`timescale 1ns/1ps
// Serialises one 8*BLOCK_BYTES-bit block onto an 8-bit stream, MSB byte first.
// Latency: first byte valid 1 cycle after acceptance; BLOCK_BYTES+1 cycles per block at full rate.
// Backpressure: tx_ready low holds tx_data/tx_valid; blk_ready stays low for the whole SEND phase.
module block_unbatcher #(
    parameter int BLOCK_BYTES = 16,
    parameter int CNT_W       = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [8*BLOCK_BYTES-1:0] blk_data,
    input  logic                     blk_valid,
    output logic                     blk_ready,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic                     busy,
    output logic [CNT_W-1:0]         blk_count
);
    localparam int BLK_W = 8 * BLOCK_BYTES;
    localparam int IDX_W = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_BYTES - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t           state;
    logic [BLK_W-1:0] shift_reg;
    logic [IDX_W-1:0] byte_idx;

    // Ready is gated by reset so the AES side sees it low for the whole reset window.
    assign blk_ready = reset && (state == IDLE);
    assign tx_data   = shift_reg[BLK_W-1 -: 8];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            byte_idx  <= '0;
            tx_valid  <= 1'b0;
            busy      <= 1'b0;
            blk_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (blk_valid && blk_ready) begin
                        shift_reg <= blk_data;
                        byte_idx  <= '0;
                        tx_valid  <= 1'b1;
                        busy      <= 1'b1;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (tx_ready) begin
                        // Shifting on the last byte too leaves the register cleared in IDLE.
                        shift_reg <= shift_reg << 8;
                        if (byte_idx == LAST_IDX) begin
                            byte_idx  <= '0;
                            tx_valid  <= 1'b0;
                            busy      <= 1'b0;
                            blk_count <= blk_count + CNT_W'(1);
                            state     <= IDLE;
                        end else begin
                            byte_idx <= byte_idx + IDX_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_block_unbatcher.sv
`timescale 1ns/1ps
// Bench for block_unbatcher: queue-based byte model with a per-cycle compare, plus directed literal checks.
module tb_block_unbatcher;
    localparam int BB = 16;
    localparam int CW = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [8*BB-1:0] blk_data = '0;
    logic            blk_valid = 1'b0;
    logic            blk_ready;
    logic [7:0]      tx_data;
    logic            tx_valid;
    logic            tx_ready = 1'b0;
    logic            busy;
    logic [CW-1:0]   blk_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    block_unbatcher #(.BLOCK_BYTES(BB), .CNT_W(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .blk_data  (blk_data),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .blk_count (blk_count)
    );

    // Reference model: a block becomes a queue of bytes; one byte leaves per accepted handshake.
    logic [7:0]    exp_q[$];
    bit            m_busy = 1'b0;
    logic [CW-1:0] m_count = '0;
    int            cyc = 0;
    int            accepts = 0;
    int            xfers = 0;
    int            acc_cyc_q[$];
    logic [7:0]    last_pop = '0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h time=%0t", nm, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk or negedge reset);
        if (!reset) begin
            exp_q.delete();
            m_busy  = 1'b0;
            m_count = '0;
        end else begin
            cyc++;
            if (!m_busy) begin
                if (blk_valid) begin
                    for (int i = BB - 1; i >= 0; i--) exp_q.push_back(blk_data[8*i +: 8]);
                    m_busy = 1'b1;
                    accepts++;
                    acc_cyc_q.push_back(cyc);
                end
            end else if (tx_ready) begin
                last_pop = exp_q.pop_front();
                xfers++;
                if (exp_q.size() == 0) begin
                    m_busy = 1'b0;
                    m_count++;
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (!reset) begin
            check("rst_blk_ready", blk_ready, 0);
            check("rst_tx_valid", tx_valid, 0);
            check("rst_busy", busy, 0);
            check("rst_blk_count", blk_count, 0);
            check("rst_tx_data", tx_data, 0);
        end else begin
            check("blk_ready", blk_ready, !m_busy);
            check("tx_valid", tx_valid, m_busy);
            check("busy", busy, m_busy);
            check("blk_count", blk_count, m_count);
            if (m_busy) check("tx_data", tx_data, exp_q[0]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8*BB-1:0] rand_blk();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic drain(input bit rnd);
        int budget;
        budget = 2000;
        while (m_busy && budget > 0) begin
            tx_ready = rnd ? ($urandom_range(0, 1) != 0) : 1'b1;
            step();
            budget--;
        end
        check("drain_idle", busy, 0);
    endtask

    task automatic send_blocks(input int n, input bit rnd, input logic [8*BB-1:0] first);
        int target;
        int budget;
        int a0;
        target = accepts + n;
        budget = 100 * n + 40;
        blk_data = first;
        blk_valid = 1'b1;
        while (accepts < target && budget > 0) begin
            a0 = accepts;
            tx_ready = rnd ? ($urandom_range(0, 1) != 0) : 1'b1;
            step();
            budget--;
            if (accepts != a0) blk_data = rand_blk();
            if (accepts == target) blk_valid = 1'b0;
        end
        blk_valid = 1'b0;
        check("send_accepts", accepts, target);
        drain(rnd);
    endtask

    initial begin
        int x0;
        int c0;
        int budget;

        // Reset held low with blk_valid asserted
        blk_valid = 1'b1;
        blk_data  = rand_blk();
        for (int i = 0; i < 10; i++) begin
            step();
            check("reset_hold_ready", blk_ready, 0);
        end
        @(negedge clk);
        reset = 1'b1;
        blk_valid = 1'b0;
        #1;
        check("ready_after_release", blk_ready, 1);

        // Single block at full rate
        @(negedge clk);
        blk_data  = 128'h000102030405060708090A0B0C0D0E0F;
        blk_valid = 1'b1;
        tx_ready  = 1'b1;
        step();
        blk_valid = 1'b0;
        for (int k = 0; k < BB; k++) begin
            check("single_valid", tx_valid, 1);
            check("single_byte", tx_data, k);
            check("single_ready_low", blk_ready, 0);
            step();
        end
        check("single_count", blk_count, 1);
        check("single_ready_back", blk_ready, 1);

        // Random backpressure on one block
        x0 = xfers;
        send_blocks(1, 1'b1, 128'hA5A5A5A5A5A5A5A5A5A5A5A5A5A50F1E);
        check("bp_bytes", xfers - x0, 16);
        check("bp_last_byte", last_pop, 8'h1E);
        check("bp_count", blk_count, 2);

        // Back-to-back blocks with blk_valid held high
        c0 = acc_cyc_q.size();
        x0 = xfers;
        send_blocks(3, 1'b0, rand_blk());
        check("b2b_gap1", acc_cyc_q[c0+1] - acc_cyc_q[c0], 17);
        check("b2b_gap2", acc_cyc_q[c0+2] - acc_cyc_q[c0+1], 17);
        check("b2b_bytes", xfers - x0, 48);
        check("b2b_count", blk_count, 5);

        // Reset pulse in the middle of a block
        @(negedge clk);
        blk_data  = rand_blk();
        blk_valid = 1'b1;
        tx_ready  = 1'b1;
        step();
        blk_valid = 1'b0;
        x0 = xfers;
        budget = 100;
        while (xfers < x0 + 6 && budget > 0) begin
            step();
            budget--;
        end
        check("mr_progress", xfers - x0, 6);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mr_tx_valid", tx_valid, 0);
        check("mr_busy", busy, 0);
        check("mr_blk_ready", blk_ready, 0);
        check("mr_blk_count", blk_count, 0);
        check("mr_tx_data", tx_data, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        blk_data  = 128'hC3112233445566778899AABBCCDDEEFF;
        blk_valid = 1'b1;
        tx_ready  = 1'b1;
        step();
        blk_valid = 1'b0;
        check("mr_first_byte", tx_data, 8'hC3);
        x0 = xfers;
        drain(1'b0);
        check("mr_bytes", xfers - x0, 16);
        check("mr_last_byte", last_pop, 8'hFF);
        check("mr_count", blk_count, 1);

        // Counter wrap: 1 + 15 blocks in a 4-bit counter
        send_blocks(15, 1'b1, rand_blk());
        check("wrap_count", blk_count, 0);
        send_blocks(1, 1'b0, rand_blk());
        check("wrap_plus_one", blk_count, 1);

        // Free-running random traffic
        repeat (1500) begin
            @(negedge clk);
            blk_valid = ($urandom_range(0, 2) != 0);
            blk_data  = rand_blk();
            tx_ready  = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        blk_valid = 1'b0;
        drain(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
